iic_sinegen_ctrl: RTL and testbench
===================================

# iic_sinegen_ctrl

Sweep and rate controller for the `iic_sinegen` sine generator. It sets the rate at which the generator advances by issuing periodic read strobes. It sweeps the generator's step size (output frequency) from a start value to a stop value, holding each step for a programmable number of reads. It sits between the register/test interface and the generator, and drives the generator's `tst_sinegen_en_i`, `tst_sinegen_step_i` and `data_rd_i` inputs.

## Interface
Parameters:
- `LUT_SIZE`, 6, must match the generator; step width is `LUT_SIZE-1`.
- `DIV_BW`, 8, width of the sample-interval divider.
- `DWELL_BW`, 12, width of the per-step read count.

Ports:
- `clk_i`  in  1  clock; rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  single-cycle start request; accepted in IDLE or DONE.
- `abort_i`  in  1  returns the block to IDLE from any state.
- `cfg_div_i`  in  DIV_BW  sample interval; one strobe every `cfg_div_i+1` cycles.
- `cfg_step_start_i`  in  LUT_SIZE-1  first step value.
- `cfg_step_stop_i`  in  LUT_SIZE-1  last step value.
- `cfg_dwell_i`  in  DWELL_BW  each step lasts `cfg_dwell_i+1` strobes.
- `cfg_loop_i`  in  1  1 = after the stop step, restart at the start step indefinitely.
- `sinegen_en_o`  out  1  connects to the generator's `tst_sinegen_en_i`.
- `sinegen_step_o`  out  LUT_SIZE-1  connects to the generator's `tst_sinegen_step_i`.
- `data_rd_o`  out  1  connects to the generator's `data_rd_i`; single-cycle strobe.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- All outputs are registered. Reset value of every output is 0.
- IDLE / DONE:
  - `sinegen_en_o`, `data_rd_o` and `busy_o` are 0; `sinegen_step_o` holds its last value.
  - On `start_i`, every `cfg_*` input is latched into shadow registers and the block enters RUN.
  - In RUN, changes on `cfg_*` are ignored until the next start.
- Sweep direction: up (+1) if shadow stop >= start, else down (-1). Step arithmetic is unsigned `LUT_SIZE-1` bits.
- RUN:
  - `sinegen_en_o` is 1.
  - Divider counter `div_cnt` is loaded with div on entry. Each cycle: if `div_cnt`==0, assert `data_rd_o` for that cycle and reload div; otherwise decrement.
  - Each strobe decrements `dwell_cnt` (loaded with dwell on entry and on each step change).
  - When `dwell_cnt`==0 at a strobe, the step ends. If step != stop: step moves by ±1 and `dwell_cnt` reloads. If step == stop and loop=1: step reloads start. If step == stop and loop=0: go to DONE.
- The generator samples `sinegen_step_o` at the same edge as the strobe, so each step value is applied to exactly dwell+1 reads.
- Non-loop total strobes = (|stop-start|+1)*(dwell+1).
- `abort_i`: from any state, the next state is IDLE. `done_o` clears. No strobe is issued in the cycle after abort is sampled.
- Simultaneous `start_i` and `abort_i`: abort wins.
- `start_i` during RUN is ignored.
- start == stop is legal: a single step, dwell+1 strobes.
- Reset mid-sweep clears all state immediately. The generator's read pointer is not reset by this block.

## Timing
- `start_i` sampled at edge E0. In the cycle after E0: `busy_o`=1, `sinegen_en_o`=1, `sinegen_step_o`=start.
- The first `data_rd_o` occurs in the (div+1)-th RUN cycle after E0. With div=0, a strobe occurs in every RUN cycle, starting in the first.
- A step change is visible in the cycle after the last strobe of the previous step.
- After the final strobe (non-loop): DONE is entered in the next cycle, with `sinegen_en_o`=0, `busy_o`=0, `done_o`=1.
- `done_o` stays high until the next accepted `start_i` (drops in the cycle after it) or `abort_i`.
- Abort latency is 1 cycle to IDLE outputs.

## Test plan
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- div=2, start=1, stop=3, dwell=1, loop=0 -> 6 strobes spaced 3 cycles apart, steps 1,1,2,2,3,3; `done_o` rises 1 cycle after the 6th strobe (18 RUN cycles).
- div=0, start=5, stop=2, dwell=0 -> strobes in 4 consecutive cycles with steps 5,4,3,2; then DONE.
- loop=1, start=stop=4, dwell=2, div=1 -> strobes every 2 cycles and step stays 4 indefinitely; `abort_i` -> IDLE in 1 cycle, no further strobe.
- `cfg_*` changed during RUN and `start_i` pulsed during RUN -> sweep is unaffected and total strobe count is unchanged.
- `start_i` and `abort_i` in the same cycle from DONE -> IDLE, `done_o`=0, `busy_o` stays 0.

Source files
------------

// File: rtl/iic_sinegen_ctrl.sv
// Sweep and rate controller for iic_sinegen.
// Issues periodic read strobes to the generator and sweeps its step size
// from a start value to a stop value, holding each step for a fixed number
// of strobes. All outputs are registered.
module iic_sinegen_ctrl #(
  parameter int LUT_SIZE = 6,
  parameter int DIV_BW   = 8,
  parameter int DWELL_BW = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DIV_BW-1:0]     cfg_div_i,
  input  logic [LUT_SIZE-2:0]   cfg_step_start_i,
  input  logic [LUT_SIZE-2:0]   cfg_step_stop_i,
  input  logic [DWELL_BW-1:0]   cfg_dwell_i,
  input  logic                  cfg_loop_i,
  output logic                  sinegen_en_o,
  output logic [LUT_SIZE-2:0]   sinegen_step_o,
  output logic                  data_rd_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int STEP_W = LUT_SIZE - 1;

  localparam logic [DIV_BW-1:0]   DIV_ONE   = DIV_BW'(1);
  localparam logic [DWELL_BW-1:0] DWELL_ONE = DWELL_BW'(1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Shadow copies of the configuration, frozen for the whole sweep
  logic [DIV_BW-1:0]   div_sh_q,   div_sh_d;
  logic [STEP_W-1:0]   start_sh_q, start_sh_d;
  logic [STEP_W-1:0]   stop_sh_q,  stop_sh_d;
  logic [DWELL_BW-1:0] dwell_sh_q, dwell_sh_d;
  logic                loop_sh_q,  loop_sh_d;

  logic [DIV_BW-1:0]   div_cnt_q,   div_cnt_d;
  logic [DWELL_BW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [STEP_W-1:0]   step_q,      step_d;

  logic rd_q, rd_d;
  logic busy_q, busy_d;
  logic en_q, en_d;
  logic done_q, done_d;

  logic sweep_up;

  // Move one step toward the stop value; wraps as plain unsigned arithmetic
  function automatic logic [STEP_W-1:0] step_advance(input logic [STEP_W-1:0] cur,
                                                     input logic              up);
    return up ? (cur + STEP_ONE) : (cur - STEP_ONE);
  endfunction

  assign sweep_up = (stop_sh_q >= start_sh_q);

  // Next-state, counters and registered-output precompute
  always_comb begin
    state_d     = state_q;
    div_sh_d    = div_sh_q;
    start_sh_d  = start_sh_q;
    stop_sh_d   = stop_sh_q;
    dwell_sh_d  = dwell_sh_q;
    loop_sh_d   = loop_sh_q;
    div_cnt_d   = div_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    step_d      = step_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d     = S_RUN;
          div_sh_d    = cfg_div_i;
          start_sh_d  = cfg_step_start_i;
          stop_sh_d   = cfg_step_stop_i;
          dwell_sh_d  = cfg_dwell_i;
          loop_sh_d   = cfg_loop_i;
          div_cnt_d   = cfg_div_i;
          dwell_cnt_d = cfg_dwell_i;
          step_d      = cfg_step_start_i;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (div_cnt_q == '0) begin
          // A strobe is being issued this cycle
          div_cnt_d = div_sh_q;
          if (dwell_cnt_q == '0) begin
            if (step_q != stop_sh_q) begin
              step_d      = step_advance(step_q, sweep_up);
              dwell_cnt_d = dwell_sh_q;
            end else if (loop_sh_q) begin
              step_d      = start_sh_q;
              dwell_cnt_d = dwell_sh_q;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    en_d   = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    rd_d   = (state_d == S_RUN) && (div_cnt_d == '0);
  end

  // State, counters, shadows and outputs; reset clears everything
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      div_sh_q    <= '0;
      start_sh_q  <= '0;
      stop_sh_q   <= '0;
      dwell_sh_q  <= '0;
      loop_sh_q   <= 1'b0;
      div_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      step_q      <= '0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_sh_q    <= div_sh_d;
      start_sh_q  <= start_sh_d;
      stop_sh_q   <= stop_sh_d;
      dwell_sh_q  <= dwell_sh_d;
      loop_sh_q   <= loop_sh_d;
      div_cnt_q   <= div_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_q      <= step_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      done_q      <= done_d;
    end
  end

  assign sinegen_en_o   = en_q;
  assign sinegen_step_o = step_q;
  assign data_rd_o      = rd_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_iic_sinegen_ctrl.sv
// Testbench for iic_sinegen_ctrl: scenario tasks compare each cycle's outputs
// against a closed-form model of the sweep schedule.
module tb_iic_sinegen_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        abort_i;
  logic [7:0]  cfg_div_i;
  logic [4:0]  cfg_step_start_i;
  logic [4:0]  cfg_step_stop_i;
  logic [11:0] cfg_dwell_i;
  logic        cfg_loop_i;
  logic        sinegen_en_o;
  logic [4:0]  sinegen_step_o;
  logic        data_rd_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  logic [8:0] obs;
  assign obs = {data_rd_o, busy_o, sinegen_en_o, done_o, sinegen_step_o};

  iic_sinegen_ctrl #(.LUT_SIZE(6), .DIV_BW(8), .DWELL_BW(12)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_step_start_i (cfg_step_start_i),
    .cfg_step_stop_i  (cfg_step_stop_i),
    .cfg_dwell_i      (cfg_dwell_i),
    .cfg_loop_i       (cfg_loop_i),
    .sinegen_en_o     (sinegen_en_o),
    .sinegen_step_o   (sinegen_step_o),
    .data_rd_o        (data_rd_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int n_steps(int st, int sp);
    return ((sp >= st) ? (sp - st) : (st - sp)) + 1;
  endfunction

  // Expected {rd, busy, en, done, step} in RUN cycle c (c=1 is the cycle after start)
  function automatic logic [8:0] model_obs(int c, int dv, int st, int sp, int dw, bit lp);
    int p, ns, last, k, idx, stp;
    bit run;
    p    = dv + 1;
    ns   = n_steps(st, sp);
    last = ns * (dw + 1) * p;
    run  = lp || (c <= last);
    k    = (c - 1) / p;
    idx  = k / (dw + 1);
    if (lp) idx = idx % ns;
    else if (idx > ns - 1) idx = ns - 1;
    stp  = (sp >= st) ? (st + idx) : (st - idx);
    return {run && ((c % p) == 0), run, run, !run, 5'(stp)};
  endfunction

  task automatic start_sweep(int dv, int st, int sp, int dw, bit lp);
    cfg_div_i        = 8'(dv);
    cfg_step_start_i = 5'(st);
    cfg_step_stop_i  = 5'(sp);
    cfg_dwell_i      = 12'(dw);
    cfg_loop_i       = lp;
    start_i          = 1'b1;
    tick();
    start_i          = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #2;
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 9'b0);
    end
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tick();
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", obs, 9'b0);
    end
  endtask

  task automatic test_sweep();
    int tv[9][4];
    int dv, st, sp, dw, last, nstr;
    logic [8:0] exp_o;
    tv[0] = '{2, 1, 3, 1};
    tv[1] = '{0, 5, 2, 0};
    tv[2] = '{1, 7, 7, 2};
    for (int i = 3; i < 9; i++)
      tv[i] = '{int'($urandom_range(3)), int'($urandom_range(31)),
                int'($urandom_range(31)), int'($urandom_range(3))};
    for (int t = 0; t < 9; t++) begin
      dv = tv[t][0]; st = tv[t][1]; sp = tv[t][2]; dw = tv[t][3];
      last = n_steps(st, sp) * (dw + 1) * (dv + 1);
      nstr = 0;
      start_sweep(dv, st, sp, dw, 1'b0);
      for (int c = 1; c <= last + 2; c++) begin
        exp_o = model_obs(c, dv, st, sp, dw, 1'b0);
        if (data_rd_o === 1'b1) nstr++;
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("FAIL sweep%0d c=%0d got=%b exp=%b", t, c, obs, exp_o);
        end
        tick();
      end
      checks++;
      if (nstr != n_steps(st, sp) * (dw + 1)) begin
        errors++;
        $display("FAIL sweep%0d_strobes got=%0d exp=%0d", t, nstr, n_steps(st, sp) * (dw + 1));
      end
    end
  endtask

  task automatic test_cfg_during_run();
    int dv, st, sp, dw, last, nstr;
    logic [8:0] exp_o;
    for (int t = 0; t < 3; t++) begin
      dv = int'($urandom_range(2)); st = int'($urandom_range(31));
      sp = int'($urandom_range(31)); dw = int'($urandom_range(2));
      last = n_steps(st, sp) * (dw + 1) * (dv + 1);
      nstr = 0;
      start_sweep(dv, st, sp, dw, 1'b0);
      for (int c = 1; c <= last + 2; c++) begin
        start_i = 1'b0;
        exp_o = model_obs(c, dv, st, sp, dw, 1'b0);
        if (data_rd_o === 1'b1) nstr++;
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("FAIL cfgrun%0d c=%0d got=%b exp=%b", t, c, obs, exp_o);
        end
        if (c < last) begin
          cfg_div_i        = 8'($urandom);
          cfg_step_start_i = 5'($urandom);
          cfg_step_stop_i  = 5'($urandom);
          cfg_dwell_i      = 12'($urandom);
          cfg_loop_i       = 1'($urandom);
          start_i          = 1'($urandom);
        end
        tick();
      end
      start_i = 1'b0;
      checks++;
      if (nstr != n_steps(st, sp) * (dw + 1)) begin
        errors++;
        $display("FAIL cfgrun%0d_strobes got=%0d exp=%0d", t, nstr, n_steps(st, sp) * (dw + 1));
      end
    end
  endtask

  task automatic test_loop_abort();
    logic [8:0] exp_o;
    start_sweep(1, 4, 4, 2, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      exp_o = model_obs(c, 1, 4, 4, 2, 1'b1);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL loop c=%0d got=%b exp=%b", c, obs, exp_o);
      end
      if (c == 40) abort_i = 1'b1;
      tick();
    end
    abort_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs !== {4'b0000, 5'd4}) begin
        errors++;
        $display("FAIL loop_abort c=%0d got=%b exp=%b", c, obs, {4'b0000, 5'd4});
      end
      tick();
    end
  endtask

  task automatic test_start_abort_done();
    start_sweep(0, 2, 3, 0, 1'b0);
    tick(); tick();
    checks++;
    if (obs !== {4'b0001, 5'd3}) begin
      errors++;
      $display("FAIL sa_done got=%b exp=%b", obs, {4'b0001, 5'd3});
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== {4'b0000, 5'd3}) begin
        errors++;
        $display("FAIL sa_idle c=%0d got=%b exp=%b", c, obs, {4'b0000, 5'd3});
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] exp_o;
    int last;
    start_sweep(1, 3, 10, 1, 1'b0);
    for (int c = 0; c < 7; c++) tick();
    #3 rst_n_i = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL areset_now got=%b exp=%b", obs, 9'b0);
    end
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tick();
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL areset_idle got=%b exp=%b", obs, 9'b0);
    end
    last = 2;
    start_sweep(0, 6, 6, 1, 1'b0);
    for (int c = 1; c <= last + 2; c++) begin
      exp_o = model_obs(c, 0, 6, 6, 1, 1'b0);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL areset_sweep c=%0d got=%b exp=%b", c, obs, exp_o);
      end
      tick();
    end
  endtask

  initial begin
    rst_n_i          = 1'b0;
    start_i          = 1'b0;
    abort_i          = 1'b0;
    cfg_div_i        = '0;
    cfg_step_start_i = '0;
    cfg_step_stop_i  = '0;
    cfg_dwell_i      = '0;
    cfg_loop_i       = 1'b0;
    #3;
    test_reset();
    test_sweep();
    test_cfg_during_run();
    test_loop_abort();
    test_start_abort_done();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
